// File: rtl/output_drain_controller_pkg.sv
// Shared NPU definitions for the output drain controller: state encoding,
// column-count width and the base-address stride wrap rule.
package output_drain_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } drain_state_e;

    // Width of a column count able to hold 0..array_m inclusive.
    function automatic int unsigned col_width(input int unsigned array_m);
        return $clog2(array_m) + 1;
    endfunction

    // Next tile base: base + stride modulo 2^addr_w, wrapping silently.
    function automatic logic [31:0] stride_wrap(input logic [31:0] base,
                                                input logic [31:0] stride,
                                                input int unsigned addr_w);
        logic [31:0] mask;
        mask = (addr_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << addr_w) - 32'd1);
        return (base + stride) & mask;
    endfunction

endpackage

// File: rtl/output_drain_controller_if.sv
// Scheduler/array handshake and address-generator drive bundle.
interface output_drain_controller_if
    import output_drain_controller_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned TILE_WIDTH = 8,
    parameter int unsigned COL_WIDTH  = col_width(8)
);
    logic                  start;
    logic [TILE_WIDTH-1:0] cfg_num_tiles;
    logic [ADDR_WIDTH-1:0] cfg_rows;
    logic [COL_WIDTH-1:0]  cfg_num_cols;
    logic [ADDR_WIDTH-1:0] cfg_base_addr;
    logic [ADDR_WIDTH-1:0] cfg_tile_stride;
    logic                  tile_ready;
    logic                  ag_on;
    logic [ADDR_WIDTH-1:0] ag_base_addr;
    logic [COL_WIDTH-1:0]  ag_num_cols;
    logic                  tile_ack;
    logic                  busy;
    logic                  done;

    // Controller side
    modport master (
        input  start, cfg_num_tiles, cfg_rows, cfg_num_cols, cfg_base_addr,
               cfg_tile_stride, tile_ready,
        output ag_on, ag_base_addr, ag_num_cols, tile_ack, busy, done
    );

    // Scheduler / array / generator side
    modport slave (
        output start, cfg_num_tiles, cfg_rows, cfg_num_cols, cfg_base_addr,
               cfg_tile_stride, tile_ready,
        input  ag_on, ag_base_addr, ag_num_cols, tile_ack, busy, done
    );
endinterface

// File: rtl/output_drain_controller.sv
// Drains systolic-array output tiles into RAM_O by pacing the output
// address generator: one enable burst of cfg_rows cycles per ready tile,
// a one-cycle HOLD gap, then the base advances by the tile stride.
module output_drain_controller
    import output_drain_controller_pkg::*;
#(
    parameter int unsigned RAM_O_SIZE = 256,
    parameter int unsigned ARRAY_M    = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(RAM_O_SIZE),
    parameter int unsigned TILE_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    output_drain_controller_if.master  bus
);
    localparam int unsigned COL_WIDTH = col_width(ARRAY_M);

    drain_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] rows_q, rows_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [ADDR_WIDTH-1:0] row_cnt_q, row_cnt_d;
    logic [TILE_WIDTH-1:0] tiles_left_q, tiles_left_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [COL_WIDTH-1:0]  cols_q, cols_d;
    logic                  ag_on_q, ag_on_d;
    logic                  tile_ack_q, tile_ack_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  zero_job_c;
    logic                  more_tiles_c;
    logic [COL_WIDTH-1:0]  cols_clamped_c;

    assign zero_job_c     = (bus.cfg_num_tiles == '0) || (bus.cfg_rows == '0);
    assign more_tiles_c   = (tiles_left_q > TILE_WIDTH'(1));
    assign cols_clamped_c = (bus.cfg_num_cols > COL_WIDTH'(ARRAY_M)) ?
                            COL_WIDTH'(ARRAY_M) : bus.cfg_num_cols;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (bus.start) state_d = zero_job_c ? ST_DONE : ST_WAIT;
            ST_WAIT:  if (bus.tile_ready) state_d = ST_DRAIN;
            ST_DRAIN: if (row_cnt_q == ADDR_WIDTH'(1)) state_d = ST_HOLD;
            ST_HOLD:  state_d = more_tiles_c ? ST_WAIT : ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so outputs align with it
    always_comb begin
        ag_on_d    = (state_d == ST_DRAIN);
        tile_ack_d = (state_q == ST_WAIT) && (state_d == ST_DRAIN);
        busy_d     = (state_d == ST_WAIT) || (state_d == ST_DRAIN) ||
                     (state_d == ST_HOLD);
        done_d     = (state_d == ST_DONE);
    end

    // Job configuration, row/tile counters and the generator base address
    always_comb begin
        rows_d       = rows_q;
        stride_d     = stride_q;
        row_cnt_d    = row_cnt_q;
        tiles_left_d = tiles_left_q;
        base_d       = base_q;
        cols_d       = cols_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    rows_d       = bus.cfg_rows;
                    stride_d     = bus.cfg_tile_stride;
                    tiles_left_d = bus.cfg_num_tiles;
                    base_d       = bus.cfg_base_addr;
                    cols_d       = cols_clamped_c;
                end
            end
            ST_WAIT: begin
                if (bus.tile_ready) row_cnt_d = rows_q;
            end
            ST_DRAIN: begin
                row_cnt_d = row_cnt_q - ADDR_WIDTH'(1);
            end
            ST_HOLD: begin
                // Base moves only on HOLD->WAIT, after the generator's last write
                if (more_tiles_c) begin
                    base_d       = ADDR_WIDTH'(stride_wrap(32'(base_q), 32'(stride_q),
                                                           ADDR_WIDTH));
                    tiles_left_d = tiles_left_q - TILE_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk) begin
        if (!reset) begin
            rows_q       <= '0;
            stride_q     <= '0;
            row_cnt_q    <= '0;
            tiles_left_q <= '0;
            base_q       <= '0;
            cols_q       <= '0;
            ag_on_q      <= 1'b0;
            tile_ack_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            rows_q       <= rows_d;
            stride_q     <= stride_d;
            row_cnt_q    <= row_cnt_d;
            tiles_left_q <= tiles_left_d;
            base_q       <= base_d;
            cols_q       <= cols_d;
            ag_on_q      <= ag_on_d;
            tile_ack_q   <= tile_ack_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.ag_on        = ag_on_q;
    assign bus.ag_base_addr = base_q;
    assign bus.ag_num_cols  = cols_q;
    assign bus.tile_ack     = tile_ack_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_output_drain_controller.sv
// Directed bench for output_drain_controller with a behavioural RAM_O
// address generator (registered enable, offset counter, base + offset).
module tb_output_drain_controller;
    import output_drain_controller_pkg::*;

    localparam int unsigned AW = 8;
    localparam int unsigned TW = 8;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    output_drain_controller_if #(.ADDR_WIDTH(AW), .TILE_WIDTH(TW), .COL_WIDTH(CW)) bus ();

    output_drain_controller #(
        .RAM_O_SIZE(256), .ARRAY_M(8), .ADDR_WIDTH(AW), .TILE_WIDTH(TW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Address generator model: write enable lags ag_on by one cycle
    logic          gen_on_q;
    logic [AW-1:0] gen_off_q;
    logic [AW-1:0] gen_addr;
    always_ff @(posedge clk) begin
        if (!reset) begin
            gen_on_q  <= 1'b0;
            gen_off_q <= '0;
        end else begin
            gen_on_q  <= bus.ag_on;
            gen_off_q <= gen_on_q ? gen_off_q + AW'(1) : '0;
        end
    end
    assign gen_addr = bus.ag_base_addr + gen_off_q;

    // Event monitor (cumulative; the stimulus takes snapshots)
    logic [AW-1:0] wr_q[$];
    int rise_q[$];
    int fall_q[$];
    int on_cnt = 0, ack_cnt = 0, done_cnt = 0;
    logic prev_on = 1'b0;
    always @(negedge clk) begin
        if (bus.ag_on === 1'b1 && !prev_on) rise_q.push_back(cyc);
        if (bus.ag_on !== 1'b1 && prev_on)  fall_q.push_back(cyc);
        if (bus.ag_on === 1'b1)    on_cnt++;
        if (gen_on_q === 1'b1)     wr_q.push_back(gen_addr);
        if (bus.tile_ack === 1'b1) ack_cnt++;
        if (bus.done === 1'b1)     done_cnt++;
        prev_on = (bus.ag_on === 1'b1);
    end

    int checks = 0;
    int errors = 0;
    int r0, f0, w0, on0, a0, d0;
    logic [AW-1:0] exp_wr[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snapshot();
        r0 = rise_q.size(); f0 = fall_q.size(); w0 = wr_q.size();
        on0 = on_cnt; a0 = ack_cnt; d0 = done_cnt;
    endtask

    task automatic start_job(input int tiles, input int rows, input int cols,
                             input int base, input int stride, output int t);
        bus.cfg_num_tiles   = TW'(tiles);
        bus.cfg_rows        = AW'(rows);
        bus.cfg_num_cols    = CW'(cols);
        bus.cfg_base_addr   = AW'(base);
        bus.cfg_tile_stride = AW'(stride);
        bus.start           = 1'b1;
        t = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int dcyc);
        bit found;
        found = 1'b0;
        dcyc  = -1;
        for (int i = 0; i < budget && !found; i++) begin
            if (bus.done === 1'b1) begin
                found = 1'b1;
                dcyc  = cyc;
            end else begin
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, 32'(found), 32'd1);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, 32'(wr_q.size() - w0), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size(); i++) begin
            if (w0 + i < wr_q.size())
                check($sformatf("%s_wr%0d", tag, i), 32'(wr_q[w0 + i]), 32'(exp_wr[i]));
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ag_on"},    32'(bus.ag_on),        32'd0);
        check({tag, "_tile_ack"}, 32'(bus.tile_ack),     32'd0);
        check({tag, "_busy"},     32'(bus.busy),         32'd0);
        check({tag, "_done"},     32'(bus.done),         32'd0);
        check({tag, "_base"},     32'(bus.ag_base_addr), 32'd0);
        check({tag, "_cols"},     32'(bus.ag_num_cols),  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int t, d;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.tile_ready = 1'b0;
        bus.cfg_num_tiles = '0;
        bus.cfg_rows = '0;
        bus.cfg_num_cols = '0;
        bus.cfg_base_addr = '0;
        bus.cfg_tile_stride = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // Single tile, ready tied high
        bus.tile_ready = 1'b1;
        snapshot();
        start_job(1, 4, 8, 'h10, 0, t);
        wait_done("t1", 40, d);
        check("t1_done_cyc", 32'(d - t), 32'd7);
        settle();
        check("t1_on_rise", 32'(rise_q[r0] - t), 32'd2);
        check("t1_on_cnt", 32'(on_cnt - on0), 32'd4);
        check("t1_acks", 32'(ack_cnt - a0), 32'd1);
        check("t1_dones", 32'(done_cnt - d0), 32'd1);
        check("t1_cols", 32'(bus.ag_num_cols), 32'd8);
        check("t1_busy_idle", 32'(bus.busy), 32'd0);
        exp_wr = '{8'h10, 8'h11, 8'h12, 8'h13};
        check_writes("t1");

        // Three tiles, cols clamped, start pulse mid-job ignored
        snapshot();
        start_job(3, 2, 12, 'h00, 'h20, t);
        @(negedge clk);
        bus.cfg_base_addr = 8'h80;
        bus.cfg_num_tiles = 8'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("t2", 60, d);
        check("t2_done_cyc", 32'(d - t), 32'd13);
        settle();
        check("t2_bursts", 32'(rise_q.size() - r0), 32'd3);
        if (rise_q.size() - r0 >= 3 && fall_q.size() - f0 >= 2) begin
            check("t2_gap0", 32'(rise_q[r0 + 1] - fall_q[f0]), 32'd2);
            check("t2_gap1", 32'(rise_q[r0 + 2] - fall_q[f0 + 1]), 32'd2);
        end
        check("t2_acks", 32'(ack_cnt - a0), 32'd3);
        check("t2_dones", 32'(done_cnt - d0), 32'd1);
        check("t2_cols", 32'(bus.ag_num_cols), 32'd8);
        check("t2_final_base", 32'(bus.ag_base_addr), 32'h40);
        exp_wr = '{8'h00, 8'h01, 8'h20, 8'h21, 8'h40, 8'h41};
        check_writes("t2");

        // Base address wrap
        snapshot();
        start_job(2, 1, 3, 'hF0, 'h20, t);
        wait_done("t3", 40, d);
        check("t3_done_cyc", 32'(d - t), 32'd7);
        settle();
        check("t3_cols", 32'(bus.ag_num_cols), 32'd3);
        exp_wr = '{8'hF0, 8'h10};
        check_writes("t3");

        // Back-pressure: tile_ready low 5 WAIT cycles before each tile
        bus.tile_ready = 1'b0;
        snapshot();
        start_job(2, 2, 8, 'h40, 'h04, t);
        for (int tile = 0; tile < 2; tile++) begin
            for (int k = 0; k < 5; k++) begin
                check($sformatf("t4_wait_busy%0d_%0d", tile, k), 32'(bus.busy), 32'd1);
                check($sformatf("t4_wait_on%0d_%0d", tile, k), 32'(bus.ag_on), 32'd0);
                if (k < 4) @(negedge clk);
            end
            bus.tile_ready = 1'b1;
            @(negedge clk);
            check($sformatf("t4_resume_on%0d", tile), 32'(bus.ag_on), 32'd1);
            check($sformatf("t4_resume_ack%0d", tile), 32'(bus.tile_ack), 32'd1);
            bus.tile_ready = 1'b0;
            repeat (3) @(negedge clk);
        end
        check("t4_done", 32'(bus.done), 32'd1);
        check("t4_busy_done", 32'(bus.busy), 32'd0);
        settle();
        check("t4_acks", 32'(ack_cnt - a0), 32'd2);
        exp_wr = '{8'h40, 8'h41, 8'h44, 8'h45};
        check_writes("t4");

        // Zero jobs: no tiles, then no rows
        bus.tile_ready = 1'b1;
        snapshot();
        start_job(0, 3, 5, 'h22, 'h01, t);
        check("t5a_done", 32'(bus.done), 32'd1);
        check("t5a_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("t5a_done_low", 32'(bus.done), 32'd0);
        start_job(2, 0, 5, 'h22, 'h01, t);
        check("t5b_done", 32'(bus.done), 32'd1);
        settle();
        check("t5_on_cnt", 32'(on_cnt - on0), 32'd0);
        check("t5_acks", 32'(ack_cnt - a0), 32'd0);

        // Reset on the second ag_on cycle, then a fresh job
        start_job(2, 4, 6, 'h30, 'h10, t);
        @(negedge clk);
        @(negedge clk);
        check("t6_on_before_rst", 32'(bus.ag_on), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check_idle_zero("t6_rst");
        check("t6_state", 32'(dut.state_q), 32'(ST_IDLE));
        reset = 1'b1;
        @(negedge clk);
        snapshot();
        start_job(1, 2, 8, 'h08, 'h00, t);
        wait_done("t6", 40, d);
        check("t6_done_cyc", 32'(d - t), 32'd5);
        settle();
        exp_wr = '{8'h08, 8'h09};
        check_writes("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
